// File: rtl/kypd_pkg.sv
// Shared definitions for the Pmod KYPD 4x4 matrix scanner: FSM states,
// position-to-hex key map, and the frame priority resolver.
package kypd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } kypd_state_e;

  // Position p = row*4 + col; 16 means no key in the frame.
  localparam logic [4:0] KEY_NONE = 5'd16;

  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [4:0] resolve_key(input logic [15:0] press);
    logic [4:0] pos;
    pos = KEY_NONE;
    for (int p = 15; p >= 0; p--) begin
      if (press[p]) pos = 5'(p);
    end
    return pos;
  endfunction

endpackage

// File: rtl/kypd_scan_timer.sv
// Column dwell timer: walks one active-low column every SCAN_DIV cycles and
// strobes the row sample point and the end of each four-column frame.
module kypd_scan_timer #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] o_col,
  output logic [1:0] o_col_idx,
  output logic       o_sample,
  output logic       o_frame_end
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

  logic [DW-1:0] r_dwell;
  logic [1:0]    r_idx;
  logic          w_last;

  assign w_last = (r_dwell == DWELL_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dwell <= '0;
      r_idx   <= '0;
    end else if (w_last) begin
      r_dwell <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_dwell <= r_dwell + DWELL_ONE;
    end
  end

  assign o_col       = ~(4'b0001 << r_idx);
  assign o_col_idx   = r_idx;
  assign o_sample    = w_last;
  assign o_frame_end = w_last && (r_idx == 2'd3);

endmodule

// File: rtl/kypd_scanner.sv
// 4x4 keypad scanner with per-frame debounce and one-cycle key_valid pulses.
// Define KYPD_REPEAT_EN to add auto-repeat while a key stays held.
module kypd_scanner
  import kypd_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("kypd_scanner: parameter out of range");
  end

  logic [1:0]  w_col_idx;
  logic        w_sample;
  logic        w_frame_end;
  logic [3:0]  r_row_meta;
  logic [3:0]  r_row_sync;
  logic [15:0] r_press;
  logic [15:0] w_frame;
  logic [4:0]  w_key;
  kypd_state_e r_state, w_state_nx;
  logic [4:0]  r_cand, w_cand_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic        w_accept;
  logic        w_rep_pulse;
  logic [3:0]  r_key_code;
  logic        r_key_valid;

  kypd_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .o_col       (col),
    .o_col_idx   (w_col_idx),
    .o_sample    (w_sample),
    .o_frame_end (w_frame_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_meta <= '1;
      r_row_sync <= '1;
      r_press    <= '0;
    end else begin
      r_row_meta <= row;
      r_row_sync <= r_row_meta;
      if (w_sample) begin
        for (int r = 0; r < 4; r++) r_press[{2'(r), w_col_idx}] <= ~r_row_sync[r];
      end
    end
  end

  // Column 3 is resolved in the same cycle it is sampled, so splice it in live.
  always_comb begin
    w_frame = r_press;
    for (int r = 0; r < 4; r++) w_frame[{2'(r), 2'd3}] = ~r_row_sync[r];
  end

  assign w_key     = resolve_key(w_frame);
  assign w_cnt_inc = (r_cnt == CNT_DONE) ? r_cnt : r_cnt + CNT_ONE;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_cnt_nx   = r_cnt;
    w_accept   = 1'b0;
    if (w_frame_end) begin
      case (r_state)
        ST_IDLE: begin
          if (w_key != KEY_NONE) begin
            w_state_nx = ST_CONFIRM;
            w_cand_nx  = w_key;
            w_cnt_nx   = CNT_ONE;
          end
        end
        ST_CONFIRM: begin
          if (w_key == KEY_NONE) begin
            w_state_nx = ST_IDLE;
          end else if (w_key == r_cand) begin
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc == CNT_DONE) begin
              w_accept   = 1'b1;
              w_state_nx = ST_HELD;
            end
          end else begin
            w_cand_nx = w_key;
            w_cnt_nx  = CNT_ONE;
          end
        end
        ST_HELD: begin
          if (w_key == KEY_NONE) begin
            w_state_nx = ST_RELEASE;
            w_cnt_nx   = CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (w_key == KEY_NONE) begin
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc == CNT_DONE) w_state_nx = ST_IDLE;
          end else begin
            w_state_nx = ST_HELD;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cand      <= KEY_NONE;
      r_cnt       <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cand      <= w_cand_nx;
      r_cnt       <= w_cnt_nx;
      r_key_valid <= w_accept | w_rep_pulse;
      if (w_accept) r_key_code <= KEY_MAP[r_cand[3:0]];
    end
  end

`ifdef KYPD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] REP_ONE   = RW'(1);

  logic [RW-1:0] r_rep_cnt;
  logic [RW-1:0] w_rep_inc;
  logic          r_rep_armed;

  assign w_rep_inc   = r_rep_cnt + REP_ONE;
  assign w_rep_pulse = w_frame_end && (r_state == ST_HELD) && (w_key != KEY_NONE) &&
                       (w_rep_inc == (r_rep_armed ? REP_NEXT : REP_FIRST));

  // Counts held frames since the accept (or last repeat); frozen during RELEASE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end else if (w_frame_end) begin
      if (w_accept || w_state_nx == ST_IDLE) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b0;
      end else if (r_state == ST_HELD && w_key != KEY_NONE) begin
        if (w_rep_pulse) begin
          r_rep_cnt   <= '0;
          r_rep_armed <= 1'b1;
        end else begin
          r_rep_cnt <= w_rep_inc;
        end
      end
    end
  end
`else
  assign w_rep_pulse = 1'b0;
`endif

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = (r_state == ST_HELD) || (r_state == ST_RELEASE);

endmodule

// File: tb/tb_kypd_scanner.sv
// Self-checking bench for kypd_scanner: frame-level reference model of the
// debounce/repeat rules driven by directed and randomized keypad activity.
module tb_kypd_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;
  localparam int R_DELAY  = 4;
  localparam int R_PERIOD = 2;
  localparam int FRAME    = 4 * SCAN_DIV;
  localparam int NONE     = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  // Reference model state (frame granularity).
  bit         m_held;
  int         m_run_key, m_run_len, m_prev_k, m_rep;
  logic [3:0] m_code;
  logic       vis_pulse, vis_held;
  logic [3:0] vis_code;

  logic [3:0] hex_of [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'h0, 4'hF, 4'hE, 4'hD};

  always #5 clk = ~clk;

  // Keypad: a pressed key shorts its row to its column when that column is low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  kypd_scanner #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB),
    .REPEAT_DELAY(R_DELAY), .REPEAT_PERIOD(R_PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  task automatic model_reset();
    m_held = 0; m_run_key = NONE; m_run_len = 0; m_prev_k = NONE; m_rep = 0;
    m_code = 4'h0; vis_pulse = 1'b0; vis_held = 1'b0; vis_code = 4'h0;
  endtask

  // A key is accepted once it has been the frame's key for DB frames in a row
  // while nothing is held; a hold ends after DB consecutive empty frames.
  task automatic model_frame(input logic [15:0] v);
    int k;
    k = NONE;
    for (int p = 15; p >= 0; p--) if (v[p]) k = p;
    if (k == m_run_key) m_run_len++;
    else begin m_run_key = k; m_run_len = 1; end
    vis_pulse = 1'b0;
    if (!m_held) begin
      if (k != NONE && m_run_len == DB) begin
        vis_pulse = 1'b1; m_held = 1; m_code = hex_of[k]; m_rep = 0;
      end
    end else if (k == NONE) begin
      if (m_run_len == DB) begin m_held = 0; m_rep = 0; end
    end else if (m_prev_k != NONE) begin
      m_rep++;
`ifdef KYPD_REPEAT_EN
      if (m_rep == R_DELAY || (m_rep > R_DELAY && (m_rep - R_DELAY) % R_PERIOD == 0))
        vis_pulse = 1'b1;
`endif
    end
    m_prev_k = k;
    vis_code = m_code;
    vis_held = m_held;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (col !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b expected 1110", col); end
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    n_checks++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_code: got %h expected 0", key_code); end
    n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b expected 0", key_held); end
    rst = 1'b0;
    model_reset();
  endtask

  // Entered #1 after the edge that starts column 0; leaves at the same phase.
  task automatic run_frame(input logic [15:0] v);
    logic [3:0] exp_col;
    logic       exp_v;
    keys = v;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << (i / SCAN_DIV));
      exp_v   = (i == 0) && vis_pulse;
      n_checks++; if (col !== exp_col) begin n_fail++; $display("FAIL col[cyc %0d]: got %b expected %b", i, col, exp_col); end
      n_checks++; if (key_valid !== exp_v) begin n_fail++; $display("FAIL key_valid[cyc %0d]: got %b expected %b", i, key_valid, exp_v); end
      n_checks++; if (key_code !== vis_code) begin n_fail++; $display("FAIL key_code[cyc %0d]: got %h expected %h", i, key_code, vis_code); end
      n_checks++; if (key_held !== vis_held) begin n_fail++; $display("FAIL key_held[cyc %0d]: got %b expected %b", i, key_held, vis_held); end
      if (key_valid === 1'b1) n_pulses++;
      @(posedge clk); #1;
    end
    model_frame(v);
  endtask

  task automatic run_frames(input logic [15:0] v, input int n);
    for (int f = 0; f < n; f++) run_frame(v);
  endtask

  task automatic test_reset();
    do_reset();
    run_frames(16'h0000, 2);
  endtask

  task automatic test_clean_press();
    int p0;
    p0 = n_pulses;
    run_frames(16'h0020, 6);
    n_checks++; if (n_pulses - p0 != 1) begin n_fail++; $display("FAIL clean_pulses: got %0d expected 1", n_pulses - p0); end
    n_checks++; if (key_code !== 4'h5) begin n_fail++; $display("FAIL clean_code: got %h expected 5", key_code); end
    n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL clean_held: got %b expected 1", key_held); end
    run_frames(16'h0000, 4);
  endtask

  task automatic test_bounce();
    int p0;
    p0 = n_pulses;
    run_frames(16'h0400, 2);
    run_frames(16'h0000, 1);
    run_frames(16'h0400, 2);
    n_checks++; if (n_pulses != p0) begin n_fail++; $display("FAIL bounce_early: got %0d expected 0", n_pulses - p0); end
    run_frames(16'h0400, 1);
    run_frames(16'h0000, 4);
    n_checks++; if (n_pulses - p0 != 1) begin n_fail++; $display("FAIL bounce_pulses: got %0d expected 1", n_pulses - p0); end
    n_checks++; if (key_code !== 4'h9) begin n_fail++; $display("FAIL bounce_code: got %h expected 9", key_code); end
  endtask

  task automatic test_multi_key();
    int p0;
    p0 = n_pulses;
    run_frames(16'h8001, 4);
    run_frames(16'h8000, 3);
    n_checks++; if (n_pulses - p0 != 1) begin n_fail++; $display("FAIL multi_pulses: got %0d expected 1", n_pulses - p0); end
    n_checks++; if (key_code !== 4'h1) begin n_fail++; $display("FAIL multi_code: got %h expected 1", key_code); end
    n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL multi_held: got %b expected 1", key_held); end
    run_frames(16'h0000, 2);
    n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL multi_release_early: got %b expected 1", key_held); end
    run_frames(16'h0000, 1);
    n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL multi_release: got %b expected 0", key_held); end
    run_frames(16'h0000, 2);
  endtask

  task automatic test_release_glitch();
    int p0;
    p0 = n_pulses;
    run_frames(16'h0100, 4);
    run_frames(16'h0000, 2);
    run_frames(16'h0100, 3);
    n_checks++; if (n_pulses - p0 != 1) begin n_fail++; $display("FAIL glitch_pulses: got %0d expected 1", n_pulses - p0); end
    n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL glitch_held: got %b expected 1", key_held); end
    run_frames(16'h0000, 4);
  endtask

  task automatic test_reset_mid_confirm();
    int p0;
    p0 = n_pulses;
    run_frames(16'h0040, 2);
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    keys = 16'h0000;
    do_reset();
    run_frames(16'h0000, 4);
    n_checks++; if (n_pulses != p0) begin n_fail++; $display("FAIL midreset_pulses: got %0d expected 0", n_pulses - p0); end
    n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL midreset_held: got %b expected 0", key_held); end
  endtask

  task automatic test_repeat();
    int p0, exp_n;
`ifdef KYPD_REPEAT_EN
    exp_n = 4;
`else
    exp_n = 1;
`endif
    p0 = n_pulses;
    run_frames(16'h0008, 12);
    run_frames(16'h0000, 4);
    n_checks++; if (n_pulses - p0 != exp_n) begin n_fail++; $display("FAIL repeat_pulses: got %0d expected %0d", n_pulses - p0, exp_n); end
    n_checks++; if (key_code !== 4'hA) begin n_fail++; $display("FAIL repeat_code: got %h expected a", key_code); end
  endtask

  task automatic test_random();
    logic [15:0] v;
    int sel;
    v = 16'h0000;
    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3)      v = 16'h0000;
      else if (sel < 6) v = (v == 16'h0000) ? (16'h0001 << $urandom_range(0, 15)) : v;
      else if (sel < 9) v = 16'h0001 << $urandom_range(0, 15);
      else              v = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      run_frames(v, $urandom_range(1, 5));
    end
    run_frames(16'h0000, 4);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_release_glitch();
    test_reset_mid_confirm();
    test_repeat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
